// File: rtl/record_stepper.sv
// record_stepper
//   Consumer stage behind the SPI-fed record FIFO. It pops one 4-byte motion
//   record at a time and plays it out as timed step/direction pulses on up to
//   four axes.
//
//   Record layout, in the order the bytes are popped:
//     B0[3:0] axis mask, B0[7:4] direction, B1 step count N,
//     B2/B3 period P (low/high byte, in clk cycles per step).
//
//   Ports
//     clk, rst_n    clock, asynchronous active-low reset
//     enable        1 = may fetch new records, 0 = finish current, then idle
//     fifo_size     number of words currently held in the FIFO
//     fifo_data     registered FIFO output, valid the cycle after read_en
//     fifo_read_en  pop one word
//     step[AXES]    step pulses, active high
//     dir[AXES]     direction levels
//     busy          state != IDLE
//     records_done  (RECORD_STEPPER_STATUS_EN only) count of completed records
//
//   Optional feature macro: RECORD_STEPPER_STATUS_EN

// Per-axis output stage: latches mask/dir at LOAD and gates the shared pulse.
module record_stepper_lane (
   input  logic clk,
   input  logic rst_n,
   input  logic ld,       // LOAD cycle
   input  logic go,       // record has N != 0, first pulse starts next cycle
   input  logic mask_in,
   input  logic dir_in,
   input  logic pulse,    // shared "step high next cycle" from the period timer
   output logic step,
   output logic dir
);
   logic mask_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask_q <= 1'b0;
         step   <= 1'b0;
         dir    <= 1'b0;
      end else if (ld) begin
         mask_q <= mask_in;
         dir    <= dir_in;
         step   <= mask_in & go;
      end else begin
         step   <= mask_q & pulse;
      end
   end
endmodule

module record_stepper #(
   parameter int AXES        = 4,
   parameter int PULSE_WIDTH = 16,
   parameter int FIFO_SIZE_W = 7
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic [FIFO_SIZE_W-1:0] fifo_size,
   input  logic [7:0]             fifo_data,
   output logic                   fifo_read_en,
   output logic [AXES-1:0]        step,
   output logic [AXES-1:0]        dir,
   output logic                   busy
`ifdef RECORD_STEPPER_STATUS_EN
   ,
   output logic [7:0]             records_done
`endif
);
   typedef enum logic [1:0] {IDLE, FETCH, LOAD, RUN} state_t;

   localparam int          STAGES = 3;                     // fetch slots F0..F3
   localparam logic [15:0] PW16   = 16'(PULSE_WIDTH);
   localparam logic [15:0] MIN_P  = 16'(2 * PULSE_WIDTH);

   state_t          state;
   logic [STAGES:0] vld_pipe;      // one-hot marker of the current fetch slot
   logic [7:0]      b0, b1, b2;
   logic [15:0]     per_cnt;       // counts Pe-1 .. 0 within one step period
   logic [15:0]     pe_m1;         // Pe-1, reload value
   logic [15:0]     pe_m_pw;       // Pe-PULSE_WIDTH, step high while per_cnt >= this
   logic [7:0]      rem;           // steps remaining, including the current one

   logic        rec_avail;
   logic [15:0] p_raw, pe, per_nxt;
   logic        period_end, last_run, pulse, ld, go;

   // Only a complete record is ever touched.
   assign rec_avail  = enable && (fifo_size >= FIFO_SIZE_W'(4));

   // B3 is on fifo_data during LOAD itself, so the period is formed from the bus.
   assign p_raw      = {fifo_data, b2};
   assign pe         = (p_raw < MIN_P) ? MIN_P : p_raw;

   assign period_end = (per_cnt == 16'd0);
   assign last_run   = (state == RUN) && period_end && (rem == 8'd1);
   assign per_nxt    = period_end ? pe_m1 : per_cnt - 16'd1;
   // Step outputs are registered, so decide the level for the next cycle here.
   assign pulse      = (state == RUN) && !last_run && (per_nxt >= pe_m_pw);
   assign ld         = (state == LOAD);
   assign go         = (b1 != 8'd0);
   assign busy       = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         vld_pipe     <= '0;
         fifo_read_en <= 1'b0;
         b0           <= 8'd0;
         b1           <= 8'd0;
         b2           <= 8'd0;
         per_cnt      <= 16'd0;
         pe_m1        <= 16'd0;
         pe_m_pw      <= 16'd0;
         rem          <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (rec_avail) begin
                  state        <= FETCH;
                  vld_pipe     <= (STAGES+1)'(1);
                  fifo_read_en <= 1'b1;
               end
            end
            FETCH: begin
               // Byte k lands on fifo_data one slot after its read_en.
               vld_pipe <= {vld_pipe[STAGES-1:0], 1'b0};
               if (vld_pipe[1]) b0 <= fifo_data;
               if (vld_pipe[2]) b1 <= fifo_data;
               if (vld_pipe[3]) begin
                  b2           <= fifo_data;
                  fifo_read_en <= 1'b0;
                  state        <= LOAD;
               end
            end
            LOAD: begin
               vld_pipe <= '0;
               pe_m1    <= pe - 16'd1;
               pe_m_pw  <= pe - PW16;
               per_cnt  <= pe - 16'd1;
               rem      <= b1;
               state    <= go ? RUN : IDLE;
            end
            RUN: begin
               per_cnt <= per_nxt;
               if (period_end) rem <= rem - 8'd1;
               if (last_run) begin
                  // Chain straight into the next record when one is waiting.
                  if (rec_avail) begin
                     state        <= FETCH;
                     vld_pipe     <= (STAGES+1)'(1);
                     fifo_read_en <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar i = 0; i < AXES; i++) begin : g_lane
      record_stepper_lane u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .ld      (ld),
         .go      (go),
         .mask_in (b0[i]),
         .dir_in  (b0[4+i]),
         .pulse   (pulse),
         .step    (step[i]),
         .dir     (dir[i])
      );
   end

`ifdef RECORD_STEPPER_STATUS_EN
   // Completion is the last RUN cycle, or a LOAD of an N=0 record.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     records_done <= 8'd0;
      else if (last_run || (ld && !go)) records_done <= records_done + 8'd1;
   end
`endif
endmodule

// File: tb/tb_record_stepper.sv
module tb_record_stepper;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic [6:0] fifo_size;
   logic [7:0] fifo_data = 8'h00;
   logic       fifo_read_en;
   logic [3:0] step, dir;
   logic       busy;
`ifdef RECORD_STEPPER_STATUS_EN
   logic [7:0] records_done;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // FIFO model: registered output, data valid the cycle after read_en.
   logic [7:0] mem [64];
   int wr_ptr = 0;
   int rd_ptr = 0;

   logic [3:0] tr_step [512];
   logic [3:0] tr_dir  [512];
   logic       tr_re   [512];
   logic       tr_busy [512];

   always #5 clk = ~clk;

   assign fifo_size = 7'(wr_ptr - rd_ptr);

   always @(posedge clk)
      if (fifo_read_en) begin
         fifo_data <= mem[rd_ptr % 64];
         rd_ptr    <= rd_ptr + 1;
      end

   record_stepper #(.AXES(4), .PULSE_WIDTH(16), .FIFO_SIZE_W(7)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .fifo_size    (fifo_size),
      .fifo_data    (fifo_data),
      .fifo_read_en (fifo_read_en),
      .step         (step),
      .dir          (dir),
      .busy         (busy)
`ifdef RECORD_STEPPER_STATUS_EN
      ,
      .records_done (records_done)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr_ptr % 64] = b;
      wr_ptr++;
   endtask

   task automatic push_rec(input logic [7:0] b0, input logic [7:0] n, input logic [15:0] p);
      push(b0); push(n); push(p[7:0]); push(p[15:8]);
   endtask

   // Index c holds what was seen at the c-th falling edge from now.
   task automatic run_trace(input int n);
      for (int c = 1; c <= n; c++) begin
         @(negedge clk);
         tr_step[c] = step;
         tr_dir[c]  = dir;
         tr_re[c]   = fifo_read_en;
         tr_busy[c] = busy;
      end
   endtask

   function automatic int hi_count(input int ax, input int n);
      int s = 0;
      for (int c = 1; c <= n; c++) s += int'(tr_step[c][ax]);
      return s;
   endfunction

   function automatic int rise_count(input int ax, input int n);
      int s = 0;
      for (int c = 2; c <= n; c++) s += int'(tr_step[c][ax] && !tr_step[c-1][ax]);
      return s;
   endfunction

   function automatic int re_count(input int n);
      int s = 0;
      for (int c = 1; c <= n; c++) s += int'(tr_re[c]);
      return s;
   endfunction

   initial begin
      int re_n, hi0;
      rst_n  = 1'b0;
      enable = 1'b0;
      #12;
      chk("rst_step", step, 0);
      chk("rst_dir", dir, 0);
      chk("rst_re", fifo_read_en, 0);
      chk("rst_busy", busy, 0);
`ifdef RECORD_STEPPER_STATUS_EN
      chk("rst_done", records_done, 0);
`endif
      @(negedge clk);
      rst_n  = 1'b1;
      enable = 1'b1;

      // 1: partial record is left alone, 4th word starts a 4-cycle fetch
      push(8'h31); push(8'd3); push(8'd100);
      run_trace(10);
      chk("partial_re", re_count(10), 0);
      chk("partial_busy", tr_busy[10], 0);
      push(8'd0);
      // 2: {B0=31, N=3, P=100}
      run_trace(320);
      chk("t1_re_first", tr_re[1], 1);
      chk("t1_re_last", tr_re[4], 1);
      chk("t1_re_off", tr_re[5], 0);
      chk("t1_re_count", re_count(320), 4);
      chk("t2_load_step", tr_step[5], 0);
      chk("t2_load_busy", tr_busy[5], 1);
      chk("t2_dir", tr_dir[6], 4'b0011);
      chk("t2_step_first", tr_step[6], 4'b0001);
      chk("t2_step_hi_end", tr_step[21], 4'b0001);
      chk("t2_step_lo", tr_step[22], 4'b0000);
      chk("t2_step_p2_pre", tr_step[105], 4'b0000);
      chk("t2_step_p2", tr_step[106], 4'b0001);
      chk("t2_hi0", hi_count(0, 320), 48);
      chk("t2_rise0", rise_count(0, 320), 3);
      chk("t2_hi_other", hi_count(1, 320) + hi_count(2, 320) + hi_count(3, 320), 0);
      chk("t2_busy_last", tr_busy[305], 1);
      chk("t2_busy_fall", tr_busy[306], 0);

      // 3: P=5 clamps to 32
      push_rec(8'h0F, 8'd2, 16'd5);
      run_trace(80);
      chk("t3_dir", tr_dir[6], 4'b0000);
      chk("t3_step_first", tr_step[6], 4'hF);
      chk("t3_step_hi_end", tr_step[21], 4'hF);
      chk("t3_step_lo", tr_step[22], 4'h0);
      chk("t3_step_p2_pre", tr_step[37], 4'h0);
      chk("t3_step_p2", tr_step[38], 4'hF);
      chk("t3_hi3", hi_count(3, 80), 32);
      chk("t3_busy_last", tr_busy[69], 1);
      chk("t3_busy_fall", tr_busy[70], 0);

      // 4: N=0 record followed by {B0=02, N=1, P=40}
      push_rec(8'h00, 8'd0, 16'd0);
      push_rec(8'h02, 8'd1, 16'd40);
      run_trace(60);
      chk("t4_n0_idle", tr_busy[6], 0);
      chk("t4_refetch", tr_re[7], 1);
      chk("t4_re_count", re_count(60), 8);
      chk("t4_step_first", tr_step[12], 4'b0010);
      chk("t4_step_hi_end", tr_step[27], 4'b0010);
      chk("t4_step_lo", tr_step[28], 4'b0000);
      chk("t4_hi1", hi_count(1, 60), 16);
      chk("t4_hi0", hi_count(0, 60), 0);
      chk("t4_busy_last", tr_busy[51], 1);
      chk("t4_busy_fall", tr_busy[52], 0);
`ifdef RECORD_STEPPER_STATUS_EN
      chk("t4_done", records_done, 4);
`endif

      // 5: enable dropped during the first RUN; second record stays queued
      push_rec(8'hA1, 8'd1, 16'd32);
      push_rec(8'hA1, 8'd1, 16'd32);
      re_n = 0;
      hi0  = 0;
      for (int c = 1; c <= 80; c++) begin
         @(negedge clk);
         re_n += int'(fifo_read_en);
         hi0  += int'(step[0]);
         if (c == 10) enable = 1'b0;
      end
      chk("t5_re_count", re_n, 4);
      chk("t5_hi0", hi0, 16);
      chk("t5_fifo_size", fifo_size, 4);
      chk("t5_busy", busy, 0);
      chk("t5_dir", dir, 4'hA);
`ifdef RECORD_STEPPER_STATUS_EN
      chk("t5_done", records_done, 5);
`endif

      // 6a: reset in the middle of FETCH
      enable = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("t6_fetch_re", fifo_read_en, 1);
      chk("t6_fetch_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6f_re", fifo_read_en, 0);
      chk("t6f_busy", busy, 0);
      chk("t6f_dir", dir, 0);
      chk("t6f_step", step, 0);
`ifdef RECORD_STEPPER_STATUS_EN
      chk("t6f_done", records_done, 0);
`endif
      @(negedge clk);
      wr_ptr = rd_ptr;
      rst_n  = 1'b1;

      // 6b: reset in the middle of RUN
      push_rec(8'h53, 8'd2, 16'd50);
      run_trace(10);
      chk("t6_run_step", tr_step[10], 4'b0011);
      chk("t6_run_dir", tr_dir[10], 4'b0101);
      #2 rst_n = 1'b0;
      #1;
      chk("t6r_step", step, 0);
      chk("t6r_dir", dir, 0);
      chk("t6r_busy", busy, 0);
      chk("t6r_re", fifo_read_en, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
